memory_bist: RTL and testbench

Hardware sweep sequencer that sits directly upstream of the synchronous single-port memory. It drives the memory's read/write/addr/data_in port and consumes data_out. On a start pulse it runs a four-pass fill/verify sweep over the whole address space and reports pass/fail with first-failure details. It replaces the software-driven sweep for built-in self-test at power-up.

---
 rtl/memory_bist_pkg.sv | 18 +
 rtl/memory_bist_checker.sv | 87 ++++++++
 rtl/memory_bist.sv | 147 ++++++++++++++
 tb/tb_memory_bist.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bist_pkg.sv
// Shared types for the memory BIST sweep sequencer: controller states and sweep phases.
package memory_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // RAMP writes each word with its own address, ZERO writes all zeros.
    typedef enum logic {
        PhRamp,
        PhZero
    } phase_e;

endpackage

// File: rtl/memory_bist_checker.sv
// Read-data compare pipeline for memory_bist: tracks the read issued last cycle,
// flags a mismatch against the returned word and captures the first failure.
module memory_bist_checker #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic [DATA_WIDTH-1:0] issue_expected_i,
    input  logic                  phase_i,
    input  logic [DATA_WIDTH-1:0] data_out_i,
    output logic                  mismatch_o,
    output logic                  fail_phase_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_expected_o,
    output logic [DATA_WIDTH-1:0] fail_actual_o
);

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_exp_q, pend_exp_d;
    logic                  fail_seen_q, fail_seen_d;
    logic                  fail_phase_q, fail_phase_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

    assign mismatch_o = pend_valid_q && (data_out_i != pend_exp_q);

    always_comb begin
        // A mismatch aborts the sweep, so the read issued alongside it is dropped.
        pend_valid_d = issue_i && !mismatch_o;
        pend_addr_d  = issue_addr_i;
        pend_exp_d   = issue_expected_i;

        fail_seen_d  = fail_seen_q;
        fail_phase_d = fail_phase_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;

        if (clear_i) begin
            fail_seen_d  = 1'b0;
            fail_phase_d = 1'b0;
            fail_addr_d  = '0;
            fail_exp_d   = '0;
            fail_act_d   = '0;
        end else if (mismatch_o && !fail_seen_q) begin
            fail_seen_d  = 1'b1;
            fail_phase_d = phase_i;
            fail_addr_d  = pend_addr_q;
            fail_exp_d   = pend_exp_q;
            fail_act_d   = data_out_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_exp_q   <= '0;
            fail_seen_q  <= 1'b0;
            fail_phase_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_exp_q   <= pend_exp_d;
            fail_seen_q  <= fail_seen_d;
            fail_phase_q <= fail_phase_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    assign fail_phase_o    = fail_phase_q;
    assign fail_addr_o     = fail_addr_q;
    assign fail_expected_o = fail_exp_q;
    assign fail_actual_o   = fail_act_q;

endmodule

// File: rtl/memory_bist.sv
// Power-up memory BIST: two fill/verify sweeps (address ramp, then zeros) over a
// synchronous single-port memory, reporting pass/fail and first-failure details.
module memory_bist
    import memory_bist_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail_phase,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out
);

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  pass_q, pass_d;

    logic                  clear;
    logic                  mismatch;
    logic                  cnt_last;
    logic                  is_write;
    logic                  is_read;
    logic [DATA_WIDTH-1:0] ramp_word;
    logic [DATA_WIDTH-1:0] expected_word;

    assign cnt_last = &cnt_q;

    // Ramp data is the address taken modulo 2**DATA_WIDTH.
    if (DATA_WIDTH <= ADDR_WIDTH) begin : g_ramp_trunc
        assign ramp_word = cnt_q[DATA_WIDTH-1:0];
    end else begin : g_ramp_ext
        assign ramp_word = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, cnt_q};
    end

    assign expected_word = (phase_q == PhRamp) ? ramp_word : '0;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWrite;
                    phase_d = PhRamp;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    clear   = 1'b1;
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (mismatch) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (mismatch) begin
                    state_d = StDone;
                end else if (phase_q == PhRamp) begin
                    state_d = StWrite;
                    phase_d = PhZero;
                end else begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= PhRamp;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign is_write = (state_q == StWrite);
    assign is_read  = (state_q == StRead);

    assign write   = is_write;
    assign read    = is_read;
    assign addr    = (is_write || is_read) ? cnt_q : '0;
    assign data_in = (is_write && phase_q == PhRamp) ? ramp_word : '0;
    assign busy    = is_write || is_read || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign pass    = pass_q;

    memory_bist_checker #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_checker (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear),
        .issue_i         (is_read),
        .issue_addr_i    (cnt_q),
        .issue_expected_i(expected_word),
        .phase_i         (phase_q == PhZero),
        .data_out_i      (data_out),
        .mismatch_o      (mismatch),
        .fail_phase_o    (fail_phase),
        .fail_addr_o     (fail_addr),
        .fail_expected_o (fail_expected),
        .fail_actual_o   (fail_actual)
    );

endmodule

// File: tb/tb_memory_bist.sv
// Bench for memory_bist: faulty-memory model, per-cycle sweep-plan reference and
// directed literal checks, plus a small-geometry instance for ramp wrap-around.
module tb_memory_bist;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int N   = 32;
    localparam int AW2 = 3;
    localparam int DW2 = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, pass, fail_phase, read, write;
    logic [AW-1:0] fail_addr, addr;
    logic [DW-1:0] fail_expected, fail_actual, data_in;
    logic [DW-1:0] data_out = '0;

    logic start2;
    logic busy2, done2, pass2, fail_phase2, read2, write2;
    logic [AW2-1:0] fail_addr2, addr2;
    logic [DW2-1:0] fail_expected2, fail_actual2, data_in2;
    logic [DW2-1:0] data_out2 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memory_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_phase(fail_phase), .fail_addr(fail_addr), .fail_expected(fail_expected),
        .fail_actual(fail_actual), .read(read), .write(write), .addr(addr),
        .data_in(data_in), .data_out(data_out)
    );

    memory_bist #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_phase(fail_phase2), .fail_addr(fail_addr2), .fail_expected(fail_expected2),
        .fail_actual(fail_actual2), .read(read2), .write(write2), .addr(addr2),
        .data_in(data_in2), .data_out(data_out2)
    );

    // Memory with one injectable fault: reads of f_addr return (word & f_and) | f_or
    // once that address has been written at least f_arm times in the current sweep.
    logic [DW-1:0] mem [N];
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_and, f_or;
    int unsigned   f_arm;
    int unsigned   wcnt = 0;

    always @(posedge clk) begin
        if (start && !busy && !done) wcnt <= 0;
        if (read) begin
            if (addr == f_addr && wcnt >= f_arm) data_out <= (mem[addr] & f_and) | f_or;
            else data_out <= mem[addr];
        end
        if (write) begin
            mem[addr] <= data_in;
            if (addr == f_addr) wcnt <= wcnt + 1;
        end
    end

    logic [DW2-1:0] mem2 [8];
    always @(posedge clk) begin
        if (read2) data_out2 <= mem2[addr2];
        if (write2) mem2[addr2] <= data_in2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference: one entry per clock cycle of a sweep, derived from the sweep rules.
    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          busy;
        logic          done;
        logic          pass;
        logic          fph;
        logic [AW-1:0] fa;
        logic [DW-1:0] fe;
        logic [DW-1:0] fx;
    } exp_t;

    exp_t plan[$];
    exp_t held = '0;
    bit   in_done = 0;

    function automatic exp_t ent(bit rd, bit wr, int a, int d);
        exp_t e = '0;
        e.rd = rd; e.wr = wr; e.a = AW'(a); e.d = DW'(d); e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t fin(bit ok, int ph, int a, logic [DW-1:0] fe, logic [DW-1:0] fx);
        exp_t e = '0;
        e.done = 1'b1; e.pass = ok; e.fph = ph[0]; e.fa = AW'(a); e.fe = fe; e.fx = fx;
        return e;
    endfunction

    task automatic build_plan();
        int fp = -1;
        int fa = int'(f_addr);
        logic [DW-1:0] stored, faulty, fexp, fact;
        fexp = '0; fact = '0;
        for (int p = 0; p < 2; p++) begin
            stored = (p == 0) ? DW'(f_addr) : '0;
            faulty = (stored & f_and) | f_or;
            if (fp < 0 && f_arm <= p + 1 && faulty != stored) begin
                fp = p; fexp = stored; fact = faulty;
            end
        end
        plan.delete();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < N; k++) plan.push_back(ent(0, 1, k, (p == 0) ? k : 0));
            for (int k = 0; k < N; k++) begin
                plan.push_back(ent(1, 0, k, 0));
                if (fp == p && k == fa + 1) begin
                    plan.push_back(fin(0, p, fa, fexp, fact));
                    return;
                end
            end
            plan.push_back(ent(0, 0, 0, 0));
            if (fp == p && fa == N - 1) begin
                plan.push_back(fin(0, p, fa, fexp, fact));
                return;
            end
        end
        plan.push_back(fin(1, 0, 0, '0, '0));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            // nothing accepted under reset
        end else if (in_done) begin
            in_done = 0;
        end else if (plan.size() == 0 && start) begin
            build_plan();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        act.rd = read; act.wr = write; act.a = addr; act.d = data_in;
        act.busy = busy; act.done = done; act.pass = pass; act.fph = fail_phase;
        act.fa = fail_addr; act.fe = fail_expected; act.fx = fail_actual;
        if (plan.size() > 0) begin
            e = plan.pop_front();
            if (e.done) begin
                held = e;
                held.done = 1'b0;
                in_done = 1;
            end
        end else begin
            e = held;
        end
        check("cycle", 64'(act), 64'(e));
    end

    logic          cap_pass, cap_ph;
    logic [AW-1:0] cap_fa;
    logic [DW-1:0] cap_fe, cap_fx;

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int bc, output int wc);
        bit seen = 0;
        bc = 0; wc = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (write) wc++;
            if (done) begin
                seen = 1;
                cap_pass = pass; cap_ph = fail_phase; cap_fa = fail_addr;
                cap_fe = fail_expected; cap_fx = fail_actual;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        int bc, wc, b, kind;
        int bc2;
        bit seen5;
        logic [DW2-1:0] w5;

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        f_addr = '0; f_and = '1; f_or = '0; f_arm = 3;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_outputs", 64'({busy, done, pass, fail_phase, fail_addr, fail_expected,
                                    fail_actual, read, write, addr, data_in}), 64'd0);

        // healthy sweep
        pulse_start();
        wait_done(bc, wc);
        check("healthy_busy_cycles", 64'(bc), 64'd130);
        check("healthy_writes", 64'(wc), 64'd64);
        check("healthy_pass", 64'(cap_pass), 64'd1);

        // bit 0 stuck at 0 at address 5
        f_addr = 5; f_and = 8'hFE; f_or = 8'h00; f_arm = 1;
        pulse_start();
        wait_done(bc, wc);
        check("stuck_pass", 64'(cap_pass), 64'd0);
        check("stuck_phase", 64'(cap_ph), 64'd0);
        check("stuck_addr", 64'(cap_fa), 64'd5);
        check("stuck_expected", 64'(cap_fe), 64'h05);
        check("stuck_actual", 64'(cap_fx), 64'h04);
        check("stuck_writes", 64'(wc), 64'd32);
        check("stuck_busy_cycles", 64'(bc), 64'd39);

        // address 31 reads 8'hFF after its zero write
        f_addr = 31; f_and = 8'hFF; f_or = 8'hFF; f_arm = 2;
        pulse_start();
        wait_done(bc, wc);
        check("ff31_pass", 64'(cap_pass), 64'd0);
        check("ff31_phase", 64'(cap_ph), 64'd1);
        check("ff31_addr", 64'(cap_fa), 64'd31);
        check("ff31_expected", 64'(cap_fe), 64'h00);
        check("ff31_actual", 64'(cap_fx), 64'hFF);
        check("ff31_busy_cycles", 64'(bc), 64'd130);

        // asynchronous reset in the middle of the RAMP read pass
        f_arm = 3;
        pulse_start();
        repeat (40) @(posedge clk);
        #1 check("pre_reset_read", 64'(read), 64'd1);
        #1 rst = 1'b1;
        plan.delete(); held = '0; in_done = 0;
        #1 check("reset_async", 64'({read, write, busy, pass}), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        pulse_start();
        wait_done(bc, wc);
        check("post_reset_busy_cycles", 64'(bc), 64'd130);
        check("post_reset_pass", 64'(cap_pass), 64'd1);

        // start held high: one sweep, then a restart only from IDLE
        @(posedge clk); #1 start = 1'b1;
        wait_done(bc, wc);
        check("held_busy_cycles", 64'(bc), 64'd130);
        @(negedge clk);
        check("held_idle", 64'({busy, pass}), 64'b01);
        @(negedge clk);
        check("held_restart", 64'({busy, pass}), 64'b10);
        start = 1'b0;
        wait_done(bc, wc);
        check("held_second_busy", 64'(bc), 64'd129);
        check("held_second_pass", 64'(cap_pass), 64'd1);

        // randomized faults, gaps and ignored start pulses
        repeat (12) begin
            kind = $urandom_range(0, 3);
            b = $urandom_range(0, 7);
            f_addr = AW'($urandom_range(0, N - 1));
            f_arm = $urandom_range(1, 2);
            case (kind)
                0: begin f_arm = 3; f_and = '1; f_or = '0; end
                1: begin f_and = ~(8'h01 << b); f_or = '0; end
                2: begin f_and = '1; f_or = 8'h01 << b; end
                default: begin f_and = DW'($urandom); f_or = DW'($urandom); end
            endcase
            repeat ($urandom_range(0, 5)) @(posedge clk);
            pulse_start();
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            wait_done(bc, wc);
        end

        // small geometry: ramp wraps modulo 4
        f_arm = 3;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        bc2 = 0; seen5 = 0; w5 = '0;
        for (int i = 0; i < 100 && !done2; i++) begin
            @(negedge clk);
            if (busy2) bc2++;
            if (write2 && addr2 == 3'd5 && !seen5) begin
                seen5 = 1;
                w5 = data_in2;
            end
        end
        check("small_done", 64'(done2), 64'd1);
        check("small_busy_cycles", 64'(bc2), 64'd34);
        check("small_pass", 64'(pass2), 64'd1);
        check("small_wrap_data", 64'(w5), 64'b01);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
